// File: rtl/threetoeight_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
// Thermometer decode is selected with THREETOEIGHT_THERM_EN.
package threetoeight_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/threetoeight_dec3to8.sv
// Combinational 3-to-8 decode: one-hot by default, thermometer (all k <= code)
// when THREETOEIGHT_THERM_EN is defined.
module dec3to8
    import threetoeight_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [LINES-1:0]  lines
);

    always_comb begin
        lines = '0;
        for (int k = 0; k < LINES; k++) begin
`ifdef THREETOEIGHT_THERM_EN
            lines[k] = (k <= int'(code));
`else
            lines[k] = (k == int'(code));
`endif
        end
    end

endmodule

// File: rtl/threetoeight_seq.sv
// Sequenced 3-to-8 decoder: drives a decoded line for HOLD cycles, then GAP
// all-zero cycles, then pulses done. Decode style follows THREETOEIGHT_THERM_EN.
//
// Handshake: a code is accepted on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, and an unaccepted valid is simply held upstream.
module threetoeight_seq
    import threetoeight_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CODE_W-1:0]   in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LINES-1:0]    out,
    output logic                busy,
    output logic                done
);

    generate
        if (HOLD < 1 || HOLD > 255 || GAP < 0 || GAP > 255 ||
            HOLD >= (1 << CNT_W) || GAP >= (1 << CNT_W)) begin : g_param_err
            $error("threetoeight_seq: illegal HOLD/GAP/CNT_W combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [LINES-1:0]    out_q, out_d;
    logic                done_q, done_d;
    logic                accept;
    logic [CODE_W-1:0]   dec_code;
    logic [LINES-1:0]    dec_lines;

    assign accept   = in_valid && (state_q == S_IDLE);
    // Decode the live input on the accepting edge so out is valid one cycle later.
    assign dec_code = accept ? in : code_q;

    dec3to8 u_dec (
        .code  (dec_code),
        .lines (dec_lines)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_d = '0;
                if (accept) begin
                    code_d  = in;
                    cnt_d   = HOLD_LOAD;
                    out_d   = dec_lines;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                out_d = dec_lines;
                if (cnt_q == '0) begin
                    out_d = '0;
                    if (GAP > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                out_d = '0;
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                out_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign out      = out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_threetoeight_seq.sv
// Bench for threetoeight_seq: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0),
// per-cycle expected {in_ready, done, busy, out} queued at each acceptance.
module tb_threetoeight_seq;

    localparam int H0 = 4;
    localparam int G0 = 1;
    localparam int H1 = 1;
    localparam int G1 = 0;
    localparam logic [10:0] IDLE_ENT = {3'b100, 8'h00};

    logic       clk;
    logic       rst_n;
    logic [2:0] in0, in1;
    logic       val0, val1;
    logic       rdy0, rdy1;
    logic [7:0] out0, out1;
    logic       busy0, busy1;
    logic       done0, done1;

    int checks;
    int errors;

    logic [10:0] exp_q0[$];
    logic [10:0] exp_q1[$];

    threetoeight_seq #(.HOLD(H0), .GAP(G0), .CNT_W(8)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in0),
        .in_valid (val0),
        .in_ready (rdy0),
        .out      (out0),
        .busy     (busy0),
        .done     (done0)
    );

    threetoeight_seq #(.HOLD(H1), .GAP(G1), .CNT_W(8)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in1),
        .in_valid (val1),
        .in_ready (rdy1),
        .out      (out1),
        .busy     (busy1),
        .done     (done1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_lines(input logic [2:0] c);
        logic [8:0] t;
`ifdef THREETOEIGHT_THERM_EN
        t = (9'd1 << (int'(c) + 1)) - 9'd1;
        return t[7:0];
`else
        t = 9'd1 << c;
        return t[7:0];
`endif
    endfunction

    // drivers
    task automatic set_in(input int sel, input logic [2:0] c, input logic v);
        if (sel == 0) begin in0 = c; val0 = v; end
        else          begin in1 = c; val1 = v; end
    endtask

    task automatic push_exp(input int sel, input logic [10:0] e);
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    task automatic push_txn(input int sel, input logic [2:0] c);
        int h, g;
        h = (sel == 0) ? H0 : H1;
        g = (sel == 0) ? G0 : G1;
        for (int i = 0; i < h; i++) push_exp(sel, {3'b001, exp_lines(c)});
        for (int i = 0; i < g; i++) push_exp(sel, {3'b001, 8'h00});
        push_exp(sel, {3'b110, 8'h00});
    endtask

    // Present code c and keep valid high until it is accepted.
    task automatic send(input int sel, input logic [2:0] c);
        int n;
        logic r;
        @(negedge clk);
        set_in(sel, c, 1'b1);
        n = 0;
        r = (sel == 0) ? rdy0 : rdy1;
        while (!r && n < 50) begin
            @(negedge clk);
            n++;
            r = (sel == 0) ? rdy0 : rdy1;
        end
        if (!r) begin
            check("accept_timeout", 32'd0, 32'd1);
            set_in(sel, c, 1'b0);
        end else begin
            @(posedge clk);
            push_txn(sel, c);
        end
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        if (sel == 0) val0 = 1'b0;
        else          val1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // scoreboard / monitor
    task automatic mon(input int sel);
        logic [10:0] got, exp;
        if (sel == 0) begin
            got = {rdy0, done0, busy0, out0};
            exp = (exp_q0.size() != 0) ? exp_q0.pop_front() : IDLE_ENT;
            check("dut0_cycle", 32'(got), 32'(exp));
        end else begin
            got = {rdy1, done1, busy1, out1};
            exp = (exp_q1.size() != 0) ? exp_q1.pop_front() : IDLE_ENT;
            check("dut1_cycle", 32'(got), 32'(exp));
        end
`ifndef THREETOEIGHT_THERM_EN
        check("onehot", 32'($countones(got[7:0]) <= 1), 32'd1);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        in0 = '0; in1 = '0; val0 = 1'b0; val1 = 1'b0;
        #12;
        check("rst_out0", 32'(out0), 32'h00);
        check("rst_ready0", 32'(rdy0), 32'd1);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_out1", 32'(out1), 32'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single code 5
        send(0, 3'd5);
        idle(0);
        drain();

        // all codes back-to-back with valid held
        for (int c = 0; c < 8; c++) send(0, 3'(c));
        idle(0);
        drain();

        // GAP=0, HOLD=1: codes 2 then 7 back-to-back
        send(1, 3'd2);
        send(1, 3'd7);
        idle(1);
        drain();

        // input changes while busy: 1 accepted, 6 waits for in_ready
        send(0, 3'd1);
        send(0, 3'd6);
        idle(0);
        drain();

        // random codes with random idle spacing on both instances
        for (int i = 0; i < 12; i++) begin
            send(i % 2, 3'($urandom_range(0, 7)));
            idle(i % 2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // reset in the middle of DRIVE
        send(0, 3'd4);
        idle(0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", 32'(out0), 32'h00);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_ready", 32'(rdy0), 32'd1);
        check("midrst_done", 32'(done0), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // recovery after reset
        send(0, 3'd3);
        idle(0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
